multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RISC-V core. It sequences the shared ALU, memory, instruction register and register file over 3–5 cycles per instruction.
- Issues ALUOp[1:0] to the existing ALU control decoder: 00 = add (address/PC math), 01 = subtract (beq compare), 10 = funct-decoded (R/I-type).
- Generates datapath mux selects, write enables and ImmSrc.
- Supports lw, sw, R-type, I-type ALU, beq and jal, with a memory-ready handshake.

Parameters:
- TRAP_ON_ILLEGAL, 1. 1 = an illegal opcode enters sticky TRAP. 0 = illegal opcode returns to FETCH with a 1-cycle Illegal pulse.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instruction opcode, from the IR
- zero  in  1  ALU zero flag
- MemReady  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write request
- IRWrite  out  1  IR / OldPC enable
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  to the ALU control decoder
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- Illegal  out  1  unsupported opcode detected
- State  out  4  current state, debug only

Behaviour:
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- Moore outputs decode from state. Exceptions: PCWrite = PCUpdate | (Branch & zero); Fetch strobes are qualified by MemReady.
- Outputs not listed for a state are 0.
- Reset:
  - Registered state is FETCH on the first cycle after reset deasserts.
  - While reset=1, all enables are forced to 0: PCWrite, MemWrite, IRWrite, RegWrite, Illegal.
  - Assertion mid-instruction aborts it at the next edge; no further writes occur.
- States, with outputs -> next state:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate assert only in the cycle MemReady=1. -> DECODE on MemReady, else hold.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). -> MEMADR (lw/sw), EXECR, EXECI, JAL, BEQ, or ILLEGAL.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. -> MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady. -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until MemReady. -> FETCH in the cycle after MemReady=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. -> ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. -> FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. -> FETCH.
  - TRAP: all enables 0, Illegal=1. Held until reset.
- Illegal opcode in DECODE:
  - TRAP_ON_ILLEGAL=1 -> TRAP.
  - TRAP_ON_ILLEGAL=0 -> Illegal=1 for the DECODE cycle only, then FETCH.
- ImmSrc is combinational on op: lw/I 00, sw 01, beq 10, jal 11, others 00. It is valid in every state.
- Cycle counts with MemReady always 1: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Each extra MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- PCWrite pulses exactly once per FETCH regardless of wait cycles.
- zero is sampled only in BEQ; ignored elsewhere.
- Unused state encodings go to FETCH on the next edge.

Decomposition:
- riscv_pkg:
  - opcode localparams
  - ALUOp encodings (ALUOP_ADD 00, ALUOP_SUB 01, ALUOP_FUNCT 10)
  - ResultSrc, ALUSrcA and ALUSrcB encodings
  - ctrl_state_t enum, 4-bit
- One sub-module: imm_src_decoder (op -> ImmSrc, combinational), shared with the single-cycle core.
- FSM next-state and output decode stay in multicycle_controller.

Test Plan:
- reset=1 for 2 cycles, then op=0000011 (lw), MemReady=1 -> States FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and ResultSrc=01 only in MEMWB. Back in FETCH at cycle 6.
- sw (0100011), MemReady low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, AdrSrc=1. PCWrite=0 throughout MEMWRITE.
- beq (1100011) with zero=1, then again with zero=0 -> PCWrite=1 in BEQ with ALUOp=01 only when zero=1. 3 cycles each.
- R-type (0110011), then jal (1101111) -> EXECR shows ALUOp=10, ALUSrcB=00. JAL state shows PCWrite=1, ALUSrcA=01, ALUSrcB=10. Both end with RegWrite in ALUWB. ImmSrc=11 for jal.
- op=1111111: TRAP_ON_ILLEGAL=1 -> stays in TRAP with Illegal=1 for 20 cycles; reset returns to FETCH. TRAP_ON_ILLEGAL=0 -> 1-cycle Illegal pulse, then FETCH.
- reset asserted during MEMWRITE with MemReady=0 -> MemWrite=0 in the reset cycle, State=FETCH afterwards. No RegWrite or PCWrite glitch.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V cores: opcodes, ALU/mux select codes and
// the multi-cycle controller state type.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
    localparam logic [1:0] RESULT_DATA      = 2'b01;
    localparam logic [1:0] RESULT_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } ctrl_state_t;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate-format select from the opcode; shared by the single- and
// multi-cycle cores, so it stays purely combinational.
module imm_src_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] ImmSrc
);

    // Opcode to immediate format; unknown opcodes fall back to I-type
    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_LW:   ImmSrc = IMM_I;
            OP_I:    ImmSrc = IMM_I;
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback over 3-5 cycles with a memory-ready handshake.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [3:0] State
);

    ctrl_state_t state_r;
    ctrl_state_t state_next_s;
    logic        pc_update_s;
    logic        branch_s;
    logic        ir_write_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic        illegal_s;

    imm_src_decoder u_imm_src_decoder (
        .op     (op),
        .ImmSrc (ImmSrc)
    );

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore output decode; unlisted outputs stay 0
    always_comb begin
        state_next_s = S_FETCH;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        ir_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RESULT_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        ALUOp        = ALUOP_ADD;
        case (state_r)
            S_FETCH: begin
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RESULT_ALURESULT;
                // PC and IR update only on the completing cycle, so waits never double-step the PC
                ir_write_s  = MemReady;
                pc_update_s = MemReady;
                if (MemReady) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW:   state_next_s = S_MEMADR;
                    OP_SW:   state_next_s = S_MEMADR;
                    OP_R:    state_next_s = S_EXECR;
                    OP_I:    state_next_s = S_EXECI;
                    OP_JAL:  state_next_s = S_JAL;
                    OP_BEQ:  state_next_s = S_BEQ;
                    default: begin
                        illegal_s    = 1'b1;
                        state_next_s = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                if (op == OP_LW) begin
                    state_next_s = S_MEMREAD;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_next_s = S_MEMWB;
                end else begin
                    state_next_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                ResultSrc    = RESULT_DATA;
                reg_write_s  = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
                if (MemReady) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                ALUSrcA      = SRCA_RS1;
                ALUSrcB      = SRCB_RS2;
                ALUOp        = ALUOP_FUNCT;
                state_next_s = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA      = SRCA_RS1;
                ALUSrcB      = SRCB_IMM;
                ALUOp        = ALUOP_FUNCT;
                state_next_s = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                pc_update_s  = 1'b1;
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA      = SRCA_RS1;
                ALUSrcB      = SRCB_RS2;
                ALUOp        = ALUOP_SUB;
                branch_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_TRAP: begin
                illegal_s    = 1'b1;
                state_next_s = S_TRAP;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    // Enables are masked during reset so an aborted instruction writes nothing
    assign PCWrite  = ~reset & (pc_update_s | (branch_s & zero));
    assign IRWrite  = ~reset & ir_write_s;
    assign MemWrite = ~reset & mem_write_s;
    assign RegWrite = ~reset & reg_write_s;
    assign Illegal  = ~reset & illegal_s;
    assign State    = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; dut traps on
// illegal opcodes, dut_nt returns to FETCH instead.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       MemReady;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] State;

    logic       PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, Illegal_b;
    logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ALUOp_b, ImmSrc_b;
    logic [3:0] State_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Illegal(Illegal), .State(State)
    );

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .MemReady(MemReady),
        .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b),
        .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ALUOp(ALUOp_b),
        .ImmSrc(ImmSrc_b), .RegWrite(RegWrite_b), .Illegal(Illegal_b), .State(State_b)
    );

    task automatic test_reset();
        reset = 1'b1; op = 7'b0000011; zero = 1'b0; MemReady = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({PCWrite, MemWrite, IRWrite, RegWrite, Illegal} !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_enables cyc%0d: got %b expected 00000", c,
                         {PCWrite, MemWrite, IRWrite, RegWrite, Illegal});
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        int st[5] = '{0, 1, 2, 3, 4};
        int rs[5] = '{2, 0, 0, 0, 1};
        op = 7'b0000011; MemReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (State !== 4'(st[c])) begin
                n_fail++; $display("FAIL lw_state cyc%0d: got %0d expected %0d", c, State, st[c]);
            end
            n_checks++;
            if (RegWrite !== (c == 4)) begin
                n_fail++; $display("FAIL lw_regwrite cyc%0d: got %b expected %b", c, RegWrite, (c == 4));
            end
            n_checks++;
            if (ResultSrc !== 2'(rs[c])) begin
                n_fail++; $display("FAIL lw_resultsrc cyc%0d: got %b expected %0d", c, ResultSrc, rs[c]);
            end
            n_checks++;
            if (AdrSrc !== (c == 3)) begin
                n_fail++; $display("FAIL lw_adrsrc cyc%0d: got %b expected %b", c, AdrSrc, (c == 3));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype_fetch_wait();
        int mr[6]  = '{0, 0, 1, 1, 1, 1};
        int st[6]  = '{0, 0, 0, 1, 6, 9};
        int pcw[6] = '{0, 0, 1, 0, 0, 0};
        op = 7'b0110011;
        for (int c = 0; c < 6; c++) begin
            MemReady = 1'(mr[c]);
            @(negedge clk);
            n_checks++;
            if (State !== 4'(st[c])) begin
                n_fail++; $display("FAIL r_state cyc%0d: got %0d expected %0d", c, State, st[c]);
            end
            n_checks++;
            if ({PCWrite, IRWrite} !== {1'(pcw[c]), 1'(pcw[c])}) begin
                n_fail++; $display("FAIL r_pcw_irw cyc%0d: got %b%b expected %0d%0d", c, PCWrite, IRWrite, pcw[c], pcw[c]);
            end
            n_checks++;
            if (RegWrite !== (c == 5)) begin
                n_fail++; $display("FAIL r_regwrite cyc%0d: got %b expected %b", c, RegWrite, (c == 5));
            end
            if (c == 4) begin
                n_checks++;
                if ({ALUOp, ALUSrcA, ALUSrcB} !== 6'b10_10_00) begin
                    n_fail++; $display("FAIL r_execr_ctrl: got %b expected 101000", {ALUOp, ALUSrcA, ALUSrcB});
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal();
        int st[4]  = '{0, 1, 8, 9};
        int pcw[4] = '{1, 0, 1, 0};
        op = 7'b1101111; MemReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (State !== 4'(st[c])) begin
                n_fail++; $display("FAIL jal_state cyc%0d: got %0d expected %0d", c, State, st[c]);
            end
            n_checks++;
            if (PCWrite !== 1'(pcw[c])) begin
                n_fail++; $display("FAIL jal_pcwrite cyc%0d: got %b expected %0d", c, PCWrite, pcw[c]);
            end
            n_checks++;
            if (RegWrite !== (c == 3)) begin
                n_fail++; $display("FAIL jal_regwrite cyc%0d: got %b expected %b", c, RegWrite, (c == 3));
            end
            n_checks++;
            if (ImmSrc !== 2'b11) begin
                n_fail++; $display("FAIL jal_immsrc cyc%0d: got %b expected 11", c, ImmSrc);
            end
            if (c == 2) begin
                n_checks++;
                if ({ALUSrcA, ALUSrcB, ALUOp} !== 6'b01_10_00) begin
                    n_fail++; $display("FAIL jal_ctrl: got %b expected 011000", {ALUSrcA, ALUSrcB, ALUOp});
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        int mr[7] = '{1, 1, 1, 0, 0, 0, 1};
        int st[7] = '{0, 1, 2, 5, 5, 5, 5};
        int mw_count = 0;
        op = 7'b0100011;
        for (int c = 0; c < 7; c++) begin
            MemReady = 1'(mr[c]);
            @(negedge clk);
            if (MemWrite === 1'b1) mw_count++;
            n_checks++;
            if (State !== 4'(st[c])) begin
                n_fail++; $display("FAIL sw_state cyc%0d: got %0d expected %0d", c, State, st[c]);
            end
            n_checks++;
            if (MemWrite !== (c >= 3)) begin
                n_fail++; $display("FAIL sw_memwrite cyc%0d: got %b expected %b", c, MemWrite, (c >= 3));
            end
            n_checks++;
            if (PCWrite !== (c == 0)) begin
                n_fail++; $display("FAIL sw_pcwrite cyc%0d: got %b expected %b", c, PCWrite, (c == 0));
            end
            n_checks++;
            if (ImmSrc !== 2'b01) begin
                n_fail++; $display("FAIL sw_immsrc cyc%0d: got %b expected 01", c, ImmSrc);
            end
            if (c >= 3) begin
                n_checks++;
                if (AdrSrc !== 1'b1) begin
                    n_fail++; $display("FAIL sw_adrsrc cyc%0d: got %b expected 1", c, AdrSrc);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (mw_count != 4) begin
            n_fail++; $display("FAIL sw_memwrite_count: got %0d expected 4", mw_count);
        end
    endtask

    task automatic test_beq();
        int st[3] = '{0, 1, 10};
        op = 7'b1100011; MemReady = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = 1'(z);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_checks++;
                if (State !== 4'(st[c])) begin
                    n_fail++; $display("FAIL beq_state z%0d cyc%0d: got %0d expected %0d", z, c, State, st[c]);
                end
                n_checks++;
                if (PCWrite !== ((c == 0) || (c == 2 && z == 1))) begin
                    n_fail++; $display("FAIL beq_pcwrite z%0d cyc%0d: got %b expected %b", z, c, PCWrite,
                                       ((c == 0) || (c == 2 && z == 1)));
                end
                n_checks++;
                if (ImmSrc !== 2'b10) begin
                    n_fail++; $display("FAIL beq_immsrc cyc%0d: got %b expected 10", c, ImmSrc);
                end
                if (c == 2) begin
                    n_checks++;
                    if (ALUOp !== 2'b01) begin
                        n_fail++; $display("FAIL beq_aluop z%0d: got %b expected 01", z, ALUOp);
                    end
                end
                @(posedge clk); #1;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        op = 7'b1111111; MemReady = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({State_b, Illegal_b} !== {4'd1, 1'b1}) begin
            n_fail++; $display("FAIL illegal_nt_decode: got state %0d illegal %b expected 1 1", State_b, Illegal_b);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({State, Illegal, PCWrite, IRWrite, RegWrite, MemWrite} !== {4'd11, 5'b10000}) begin
                n_fail++; $display("FAIL trap_hold cyc%0d: got state %0d ill/pc/ir/rw/mw %b expected 11 10000", c, State,
                                   {Illegal, PCWrite, IRWrite, RegWrite, MemWrite});
            end
            if (c == 0) begin
                n_checks++;
                if ({State_b, Illegal_b} !== {4'd0, 1'b0}) begin
                    n_fail++; $display("FAIL illegal_nt_return: got state %0d illegal %b expected 0 0", State_b, Illegal_b);
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (Illegal !== 1'b0) begin
            n_fail++; $display("FAIL trap_reset_mask: got %b expected 0", Illegal);
        end
        @(posedge clk); #1;
        reset = 1'b0; op = 7'b0100011; MemReady = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({State, State_b} !== 8'h00) begin
            n_fail++; $display("FAIL trap_reset_state: got %0d/%0d expected 0/0", State, State_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        op = 7'b0100011; MemReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); @(posedge clk); #1;
        end
        MemReady = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({State, MemWrite} !== {4'd5, 1'b1}) begin
            n_fail++; $display("FAIL abort_pre: got state %0d memwrite %b expected 5 1", State, MemWrite);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({MemWrite, RegWrite, PCWrite, IRWrite} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_reset_cycle: got %b expected 0000", {MemWrite, RegWrite, PCWrite, IRWrite});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({State, MemWrite, RegWrite, PCWrite} !== {4'd0, 3'b000}) begin
            n_fail++; $display("FAIL abort_after: got state %0d mw/rw/pc %b expected 0 000", State,
                               {MemWrite, RegWrite, PCWrite});
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_fetch_wait();
        test_jal();
        test_sw_wait();
        test_beq();
        test_illegal();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
